// File: rtl/i2s_tx.sv
// I2S master transmitter: generates BCLK/LRCLK and serialises one stereo
// sample per frame, fed through a one-deep valid/ready holding buffer.
module i2s_tx #(
  parameter int unsigned DATA_W   = 24,
  parameter int unsigned SLOT_W   = 32,
  parameter int unsigned BCLK_DIV = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] left_in,
  input  logic [DATA_W-1:0] right_in,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              BCLK,
  output logic              LRCLK,
  output logic              DAC_SDATA,
  output logic              frame_start,
  output logic              underrun
);

  localparam int unsigned CNT_W = $clog2(2 * SLOT_W);
  localparam int unsigned DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

  logic [DIV_W-1:0]  div_cnt_q,   div_cnt_d;
  logic              bclk_q,      bclk_d;
  logic [CNT_W-1:0]  bit_cnt_q,   bit_cnt_d;
  logic              lrclk_q,     lrclk_d;
  logic              sdata_q,     sdata_d;
  logic              fstart_q,    fstart_d;
  logic              urun_q,      urun_d;
  logic              hold_full_q, hold_full_d;
  logic              ready_q,     ready_d;
  logic [DATA_W-1:0] hold_l_q,    hold_l_d;
  logic [DATA_W-1:0] hold_r_q,    hold_r_d;
  logic [DATA_W-1:0] shadow_l_q,  shadow_l_d;
  logic [DATA_W-1:0] shadow_r_q,  shadow_r_d;

  logic              tick;
  logic              fall;
  logic [CNT_W-1:0]  pos;
  logic [DATA_W-1:0] chan;
  logic [DATA_W-1:0] shifted;

  // Next-state: bit clock divider, slot sequencing, frame load and buffer.
  always_comb begin
    div_cnt_d   = div_cnt_q;
    bclk_d      = bclk_q;
    bit_cnt_d   = bit_cnt_q;
    lrclk_d     = lrclk_q;
    sdata_d     = sdata_q;
    fstart_d    = 1'b0;
    urun_d      = 1'b0;
    hold_full_d = hold_full_q;
    hold_l_d    = hold_l_q;
    hold_r_d    = hold_r_q;
    shadow_l_d  = shadow_l_q;
    shadow_r_d  = shadow_r_q;
    pos         = '0;
    chan        = '0;
    shifted     = '0;

    tick = (div_cnt_q == DIV_W'(BCLK_DIV - 1));
    fall = tick & bclk_q;

    div_cnt_d = tick ? '0 : div_cnt_q + DIV_W'(1);
    bclk_d    = tick ? ~bclk_q : bclk_q;

    if (fall) begin
      bit_cnt_d = (bit_cnt_q == CNT_W'(2 * SLOT_W - 1)) ? '0 : bit_cnt_q + CNT_W'(1);
      lrclk_d   = (bit_cnt_d >= CNT_W'(SLOT_W));
      pos       = lrclk_d ? bit_cnt_d - CNT_W'(SLOT_W) : bit_cnt_d;
      chan      = lrclk_d ? shadow_r_q : shadow_l_q;
      // MSB at position 1; position 0 is the I2S one-bit delay
      if (pos >= CNT_W'(1) && pos <= CNT_W'(DATA_W)) begin
        shifted = chan << (pos - CNT_W'(1));
        sdata_d = shifted[DATA_W-1];
      end else begin
        sdata_d = 1'b0;
      end

      if (bit_cnt_d == '0) begin
        fstart_d = 1'b1;
        if (hold_full_q) begin
          shadow_l_d  = hold_l_q;
          shadow_r_d  = hold_r_q;
          hold_full_d = 1'b0;
        end else begin
          urun_d = 1'b1;
        end
      end
    end

    // Accept only when empty, so it never collides with a consuming load
    if (in_valid && !hold_full_q) begin
      hold_l_d    = left_in;
      hold_r_d    = right_in;
      hold_full_d = 1'b1;
    end

    ready_d = ~hold_full_d;
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt_q   <= '0;
      bclk_q      <= 1'b0;
      bit_cnt_q   <= CNT_W'(2 * SLOT_W - 1);
      lrclk_q     <= 1'b1;
      sdata_q     <= 1'b0;
      fstart_q    <= 1'b0;
      urun_q      <= 1'b0;
      hold_full_q <= 1'b0;
      ready_q     <= 1'b1;
      hold_l_q    <= '0;
      hold_r_q    <= '0;
      shadow_l_q  <= '0;
      shadow_r_q  <= '0;
    end else begin
      div_cnt_q   <= div_cnt_d;
      bclk_q      <= bclk_d;
      bit_cnt_q   <= bit_cnt_d;
      lrclk_q     <= lrclk_d;
      sdata_q     <= sdata_d;
      fstart_q    <= fstart_d;
      urun_q      <= urun_d;
      hold_full_q <= hold_full_d;
      ready_q     <= ready_d;
      hold_l_q    <= hold_l_d;
      hold_r_q    <= hold_r_d;
      shadow_l_q  <= shadow_l_d;
      shadow_r_q  <= shadow_r_d;
    end
  end

  assign in_ready    = ready_q;
  assign BCLK        = bclk_q;
  assign LRCLK       = lrclk_q;
  assign DAC_SDATA   = sdata_q;
  assign frame_start = fstart_q;
  assign underrun    = urun_q;

endmodule
